// File: rtl/rom_resp_pkg.sv
// rom_resp_pkg - shared types and helpers for the ROM responder.
//   state_t   : responder FSM states
//   OOB_FILL  : byte returned for out-of-bounds requests
//   byte_sel  : little-endian byte-lane select from a 32-bit word
package rom_resp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LOOKUP,
      S_SRAM_WAIT,
      S_RESP,
      S_RECOVER
   } state_t;

   localparam logic [7:0] OOB_FILL = 8'h00;

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rom_word_buf.sv
// rom_word_buf - one-word read buffer in front of the boot SRAM.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_inval      : clear valid on the next edge (wins over i_fill)
//   i_fill       : load i_tag/i_fill_data and mark valid
//   i_tag        : word tag (byte address [31:2]) for both fill and lookup
//   i_fill_data  : SRAM word to store
//   o_hit        : valid and stored tag equals i_tag
//   o_data       : stored word
module rom_word_buf
   import rom_resp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_inval,
   input  logic        i_fill,
   input  logic [29:0] i_tag,
   input  logic [31:0] i_fill_data,
   output logic        o_hit,
   output logic [31:0] o_data
);

   logic        r_valid;
   logic [29:0] r_tag;
   logic [31:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         if (i_inval)
            r_valid <= 1'b0;
         else if (i_fill)
            r_valid <= 1'b1;
         if (i_fill) begin
            r_tag  <= i_tag;
            r_data <= i_fill_data;
         end
      end
   end

   assign o_hit  = r_valid && (r_tag == i_tag);
   assign o_data = r_data;

endmodule

// File: rtl/rom_responder.sv
// rom_responder - responder end of the byte-wide boot ROM read interface,
// backed by a 32-bit boot SRAM.
// Optional feature macro: ROM_WORD_BUF_EN (one-word read buffer; when
// undefined every in-bounds request reads the SRAM and rom_inval is ignored).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   rom_read_en   : request (only 1'b1 counts)
//   rom_addr      : byte address, latched on accept
//   rom_ready     : one-cycle response strobe
//   rom_data_out  : response byte, held until the next response
//   rom_inval     : invalidate the word buffer
//   sram_rd_en    : one-cycle SRAM read strobe
//   sram_addr     : SRAM word address (latched rom_addr[SRAM_AW+1:2])
//   sram_rdata    : SRAM read word, little-endian
//   oob_err       : sticky out-of-bounds flag
module rom_responder
   import rom_resp_pkg::*;
#(
   parameter int unsigned ROM_BYTES  = 4096,
   parameter int unsigned SRAM_AW    = 10,
   parameter int unsigned SRAM_LAT   = 1,
   parameter int unsigned EXTRA_WAIT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rom_read_en,
   input  logic [31:0]        rom_addr,
   output logic               rom_ready,
   output logic [7:0]         rom_data_out,
   input  logic               rom_inval,
   output logic               sram_rd_en,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [31:0]        sram_rdata,
   output logic               oob_err
);

   localparam logic [31:0] LP_ROM_BYTES = 32'(ROM_BYTES);
   localparam logic [2:0]  LP_WAIT_LAST = 3'(EXTRA_WAIT - 1);
   // SRAM_WAIT spans the strobe cycle plus SRAM_LAT cycles
   localparam logic [2:0]  LP_SRAM_LAST = 3'(SRAM_LAT);

   state_t             r_state, w_state_nxt;
   logic [31:0]        r_addr;
   logic [2:0]         r_cnt;
   logic [7:0]         r_byte;
   logic [7:0]         r_data_out;
   logic               r_ready;
   logic               r_rd_en;
   logic               r_oob;
   logic [SRAM_AW-1:0] r_sram_addr;

   logic               w_accept;
   logic               w_oob;
   logic               w_hit;
   logic               w_miss;
   logic               w_sram_done;
   logic [31:0]        w_buf_word;

   // X/Z on rom_read_en evaluates false, so only a clean 1 is a request
   assign w_accept    = (r_state == S_IDLE) && (rom_read_en == 1'b1);
   assign w_oob       = (r_addr >= LP_ROM_BYTES);
   assign w_sram_done = (r_state == S_SRAM_WAIT) && (r_cnt == LP_SRAM_LAST);

`ifdef ROM_WORD_BUF_EN
   logic r_inval_pend;
   logic w_buf_hit;
   logic w_fill;

   // An inval seen while the SRAM read is in flight drops the fill,
   // but the response itself is still served from sram_rdata.
   assign w_fill = w_sram_done && !r_inval_pend && !rom_inval;
   // inval in the LOOKUP cycle forces a miss
   assign w_hit  = w_buf_hit && !rom_inval;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_inval_pend <= 1'b0;
      else if (w_miss)
         r_inval_pend <= 1'b0;
      else if ((r_state == S_SRAM_WAIT) && rom_inval)
         r_inval_pend <= 1'b1;
   end

   rom_word_buf u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inval     (rom_inval),
      .i_fill      (w_fill),
      .i_tag       (r_addr[31:2]),
      .i_fill_data (sram_rdata),
      .o_hit       (w_buf_hit),
      .o_data      (w_buf_word)
   );
`else
   logic w_unused;
   assign w_unused   = rom_inval;
   assign w_hit      = 1'b0;
   assign w_buf_word = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_miss      = 1'b0;
      case (r_state)
         S_IDLE:
            if (w_accept)
               w_state_nxt = (EXTRA_WAIT > 0) ? S_WAIT : S_LOOKUP;
         S_WAIT:
            if (r_cnt == LP_WAIT_LAST)
               w_state_nxt = S_LOOKUP;
         S_LOOKUP:
            if (w_oob || w_hit) begin
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_SRAM_WAIT;
               w_miss      = 1'b1;
            end
         S_SRAM_WAIT:
            if (w_sram_done)
               w_state_nxt = S_RESP;
         S_RESP:
            w_state_nxt = S_RECOVER;
         S_RECOVER:
            w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered out of RESP, so rom_ready is visible during
   // RECOVER; that is the cycle in which a stale held request is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_cnt       <= '0;
         r_byte      <= '0;
         r_data_out  <= '0;
         r_ready     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_oob       <= 1'b0;
         r_sram_addr <= '0;
      end else begin
         r_ready <= (r_state == S_RESP);
         r_rd_en <= w_miss;
         r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 3'd1;
         if (r_state == S_RESP)
            r_data_out <= r_byte;
         if (w_accept) begin
            r_addr      <= rom_addr;
            r_sram_addr <= rom_addr[SRAM_AW+1:2];
         end
         if (r_state == S_LOOKUP) begin
            if (w_oob) begin
               r_byte <= OOB_FILL;
               r_oob  <= 1'b1;
            end else if (w_hit) begin
               r_byte <= byte_sel(w_buf_word, r_addr[1:0]);
            end
         end
         if (w_sram_done)
            r_byte <= byte_sel(sram_rdata, r_addr[1:0]);
      end
   end

   assign rom_ready    = r_ready;
   assign rom_data_out = r_data_out;
   assign sram_rd_en   = r_rd_en;
   assign sram_addr    = r_sram_addr;
   assign oob_err      = r_oob;

endmodule

// File: tb/tb_rom_responder.sv
// tb_rom_responder - directed self-checking bench for rom_responder.
// Expected latencies/SRAM access counts follow ROM_WORD_BUF_EN.
module tb_rom_responder;

`ifdef ROM_WORD_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   localparam int LHIT = BUF ? 2 : 4;

   logic        clk;
   logic        rst_n;
   logic        rom_read_en;
   logic [31:0] rom_addr;
   logic        rom_ready;
   logic [7:0]  rom_data_out;
   logic        rom_inval;
   logic        sram_rd_en;
   logic [9:0]  sram_addr;
   logic [31:0] sram_rdata;
   logic        oob_err;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cnt   = 0;
   int rdy_cnt  = 0;
   logic [9:0] rd_addr_log [$];

   rom_responder #(
      .ROM_BYTES  (4096),
      .SRAM_AW    (10),
      .SRAM_LAT   (1),
      .EXTRA_WAIT (0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rom_read_en  (rom_read_en),
      .rom_addr     (rom_addr),
      .rom_ready    (rom_ready),
      .rom_data_out (rom_data_out),
      .rom_inval    (rom_inval),
      .sram_rd_en   (sram_rd_en),
      .sram_addr    (sram_addr),
      .sram_rdata   (sram_rdata),
      .oob_err      (oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sram_word(input logic [9:0] wa);
      case (wa)
         10'd0:   return 32'h6D736100;
         10'd1:   return 32'hAABBCCDD;
         10'd12:  return 32'h0C0B0A09;
         10'd13:  return 32'h1D1C1B1A;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   // SRAM model, one cycle read latency, plus event counters
   always @(posedge clk) begin
      if (sram_rd_en === 1'b1) begin
         sram_rdata <= sram_word(sram_addr);
         rd_cnt = rd_cnt + 1;
         rd_addr_log.push_back(sram_addr);
      end
      if (rom_ready === 1'b1)
         rdy_cnt = rdy_cnt + 1;
   end

   // Loader-style read; rom_addr is scrambled after accept to show it is latched.
   // inval_at: cycle index after accept during which rom_inval is high (-1: none).
   task automatic do_read(input logic [31:0] a, input int inval_at,
                          output logic [7:0] d, output int lat, output logic rdy_after);
      @(negedge clk);
      rom_read_en = 1'b1;
      rom_addr    = a;
      @(posedge clk); #1;
      rom_read_en = 1'b0;
      rom_addr    = 32'hDEADBEEF;
      rom_inval   = (inval_at == 0);
      lat = 0;
      d   = 8'hxx;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         rom_inval = (lat == inval_at);
         if (rom_ready === 1'b1) begin
            d = rom_data_out;
            break;
         end
      end
      rom_inval = 1'b0;
      @(posedge clk); #1;
      rdy_after = rom_ready;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; rom_read_en = 1'b0; rom_addr = '0; rom_inval = 1'b0; sram_rdata = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (rom_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rom_ready); end
      n_checks++; if (rom_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rom_data_out); end
      n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", sram_rd_en); end
      n_checks++; if (sram_addr !== 10'd0) begin n_fail++; $display("FAIL reset_sram_addr: got %h expected 000", sram_addr); end
      n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b expected 0", oob_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sequential;
      logic [7:0] exp_d [4] = '{8'h00, 8'h61, 8'h73, 8'h6D};
      int         exp_l [4] = '{4, LHIT, LHIT, LHIT};
      logic [7:0] d; int lat; logic ra; int rd0;
      rd0 = rd_cnt;
      for (int i = 0; i < 4; i++) begin
         do_read(32'(i), -1, d, lat, ra);
         n_checks++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", i, d, exp_d[i]); end
         n_checks++; if (lat != exp_l[i]) begin n_fail++; $display("FAIL seq_lat[%0d]: got %0d expected %0d", i, lat, exp_l[i]); end
         n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL seq_ready_width[%0d]: got %b expected 0", i, ra); end
      end
      n_checks++; if (rd_cnt - rd0 != (BUF ? 1 : 4)) begin n_fail++; $display("FAIL seq_sram_reads: got %0d expected %0d", rd_cnt - rd0, BUF ? 1 : 4); end
   endtask

   task automatic test_word_cross;
      logic [7:0] d; int lat; logic ra; int rd0;
      rd0 = rd_cnt;
      rd_addr_log.delete();
      do_read(32'h30, -1, d, lat, ra);
      n_checks++; if (d !== 8'h09) begin n_fail++; $display("FAIL cross_data30: got %h expected 09", d); end
      do_read(32'h34, -1, d, lat, ra);
      n_checks++; if (d !== 8'h1A) begin n_fail++; $display("FAIL cross_data34: got %h expected 1a", d); end
      n_checks++; if (rd_cnt - rd0 != 2) begin n_fail++; $display("FAIL cross_sram_reads: got %0d expected 2", rd_cnt - rd0); end
      n_checks++; if (rd_addr_log.size() != 2) begin n_fail++; $display("FAIL cross_addr_log: got %0d entries expected 2", rd_addr_log.size()); end
      else begin
         n_checks++; if (rd_addr_log[0] !== 10'd12) begin n_fail++; $display("FAIL cross_addr0: got %0d expected 12", rd_addr_log[0]); end
         n_checks++; if (rd_addr_log[1] !== 10'd13) begin n_fail++; $display("FAIL cross_addr1: got %0d expected 13", rd_addr_log[1]); end
      end
   endtask

   task automatic test_hold_high;
      int n_pulse; int idx [$]; logic [7:0] dq [$]; int rd0;
      int exp2;
      exp2 = BUF ? 8 : 10;
      rd0 = rd_cnt;
      n_pulse = 0;
      @(negedge clk);
      rom_read_en = 1'b1;
      rom_addr    = 32'd5;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (i == 9) rom_read_en = 1'b0;
         if (rom_ready === 1'b1) begin
            n_pulse++;
            idx.push_back(i);
            dq.push_back(rom_data_out);
         end
      end
      n_checks++; if (n_pulse != 2) begin n_fail++; $display("FAIL hold_pulses: got %0d expected 2", n_pulse); end
      else begin
         n_checks++; if (idx[0] != 4) begin n_fail++; $display("FAIL hold_first_at: got %0d expected 4", idx[0]); end
         n_checks++; if (idx[1] != exp2) begin n_fail++; $display("FAIL hold_second_at: got %0d expected %0d", idx[1], exp2); end
         n_checks++; if (dq[0] !== 8'hCC) begin n_fail++; $display("FAIL hold_data0: got %h expected cc", dq[0]); end
         n_checks++; if (dq[1] !== 8'hCC) begin n_fail++; $display("FAIL hold_data1: got %h expected cc", dq[1]); end
      end
      n_checks++; if (rd_cnt - rd0 != (BUF ? 1 : 2)) begin n_fail++; $display("FAIL hold_sram_reads: got %0d expected %0d", rd_cnt - rd0, BUF ? 1 : 2); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_oob;
      logic [7:0] d; int lat; logic ra; int rd0;
      rd0 = rd_cnt;
      do_read(32'h1000, -1, d, lat, ra);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL oob_data: got %h expected 00", d); end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL oob_lat: got %0d expected 2", lat); end
      n_checks++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_flag: got %b expected 1", oob_err); end
      do_read(32'h8000_0001, -1, d, lat, ra);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL oob_hi_lat: got %0d expected 2", lat); end
      n_checks++; if (rd_cnt - rd0 != 0) begin n_fail++; $display("FAIL oob_sram_reads: got %0d expected 0", rd_cnt - rd0); end
      do_read(32'h0FFF, -1, d, lat, ra);
      n_checks++; if (d !== 8'hDE) begin n_fail++; $display("FAIL oob_edge_data: got %h expected de", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL oob_edge_lat: got %0d expected 4", lat); end
      do_read(32'h1, -1, d, lat, ra);
      n_checks++; if (d !== 8'h61) begin n_fail++; $display("FAIL oob_after_data: got %h expected 61", d); end
      n_checks++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %b expected 1", oob_err); end
   endtask

   task automatic test_inval;
      logic [7:0] d; int lat; logic ra; int rd0;
      rd0 = rd_cnt;
      do_read(32'h0, -1, d, lat, ra);
      n_checks++; if (lat != LHIT) begin n_fail++; $display("FAIL inval_pre_lat: got %0d expected %0d", lat, LHIT); end
      @(negedge clk); rom_inval = 1'b1;
      @(negedge clk); rom_inval = 1'b0;
      do_read(32'h1, -1, d, lat, ra);
      n_checks++; if (d !== 8'h61) begin n_fail++; $display("FAIL inval_idle_data: got %h expected 61", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL inval_idle_lat: got %0d expected 4", lat); end
      n_checks++; if (rd_cnt - rd0 != (BUF ? 1 : 2)) begin n_fail++; $display("FAIL inval_idle_reads: got %0d expected %0d", rd_cnt - rd0, BUF ? 1 : 2); end
      do_read(32'h4, 1, d, lat, ra);
      n_checks++; if (d !== 8'hDD) begin n_fail++; $display("FAIL inval_sw_data: got %h expected dd", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL inval_sw_lat: got %0d expected 4", lat); end
      do_read(32'h5, -1, d, lat, ra);
      n_checks++; if (d !== 8'hCC) begin n_fail++; $display("FAIL inval_sw_next_data: got %h expected cc", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL inval_sw_next_lat: got %0d expected 4", lat); end
      do_read(32'h6, 0, d, lat, ra);
      n_checks++; if (d !== 8'hBB) begin n_fail++; $display("FAIL inval_lookup_data: got %h expected bb", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL inval_lookup_lat: got %0d expected 4", lat); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d; int lat; logic ra; int rdy0;
      @(negedge clk);
      rom_read_en = 1'b1;
      rom_addr    = 32'h2;
      @(posedge clk); #1;
      rom_read_en = 1'b0;
      @(posedge clk); #1;
      rdy0  = rdy_cnt;
      rst_n = 1'b0;
      #1;
      n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b expected 0", sram_rd_en); end
      n_checks++; if (sram_addr !== 10'd0) begin n_fail++; $display("FAIL rstmid_sram_addr: got %h expected 000", sram_addr); end
      n_checks++; if (rom_data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", rom_data_out); end
      n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_oob: got %b expected 0", oob_err); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (rdy_cnt != rdy0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", rdy_cnt - rdy0); end
      do_read(32'h2, -1, d, lat, ra);
      n_checks++; if (d !== 8'h73) begin n_fail++; $display("FAIL rstmid_after_data: got %h expected 73", d); end
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rstmid_after_lat: got %0d expected 4", lat); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_word_cross();
      test_hold_high();
      test_oob();
      test_inval();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_responder.md
Name: rom_responder

Overview:
Target (responder) end of the byte-wide ROM read interface driven by the WASM boot loader. Serves single-byte requests (`rom_read_en`/`rom_addr`) from a 32-bit-wide boot SRAM and answers with a one-cycle `rom_ready` pulse carrying `rom_data_out`. Sits between the loader and the boot SRAM macro. Holds a one-word read buffer so that sequential byte fetches cost one SRAM access per word.

Parameters:
- ROM_BYTES, 4096: ROM size in bytes; must be a multiple of 4. Addresses >= ROM_BYTES are out of bounds.
- SRAM_AW, 10: SRAM word address width. Must satisfy 2^SRAM_AW*4 >= ROM_BYTES.
- SRAM_LAT, 1: cycles from the `sram_rd_en` cycle to `sram_rdata` valid; range 1..4.
- EXTRA_WAIT, 0: added wait cycles before every response; range 0..7.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_read_en  in  1  request. Only a value of exactly 1'b1 counts as a request; 0, X and Z mean idle.
- rom_addr  in  32  byte address; sampled only when a request is accepted.
- rom_ready  out  1  one-cycle response strobe.
- rom_data_out  out  8  response byte; valid while `rom_ready`=1 and held until the next response.
- rom_inval  in  1  pulse; invalidates the word buffer.
- sram_rd_en  out  1  one-cycle read strobe to SRAM.
- sram_addr  out  SRAM_AW  word address, equal to the latched `rom_addr[SRAM_AW+1:2]`.
- sram_rdata  in  32  read word, little-endian: byte 0 = bits [7:0].
- oob_err  out  1  sticky out-of-bounds flag.

Behaviour:
- Reset values: `rom_ready`=0, `rom_data_out`=8'h00, `sram_rd_en`=0, `sram_addr`=0, `oob_err`=0, buffer invalid, state IDLE.
- States:
  - IDLE: `rom_read_en`=1 latches `rom_addr` and goes to WAIT if EXTRA_WAIT>0, otherwise to LOOKUP.
  - WAIT: counts EXTRA_WAIT cycles, then LOOKUP.
  - LOOKUP resolves the request in priority order:
    1. OOB (addr >= ROM_BYTES): data 8'h00, set `oob_err`, go to RESP.
    2. Buffer hit (valid and tag == addr[31:2]): select the byte, go to RESP.
    3. Otherwise: assert `sram_rd_en` for 1 cycle, go to SRAM_WAIT.
  - SRAM_WAIT: counts SRAM_LAT cycles, captures `sram_rdata`, fills the buffer, selects byte addr[1:0], goes to RESP.
  - RESP: `rom_ready`=1 for exactly one cycle, then RECOVER.
  - RECOVER: one cycle with `rom_read_en` ignored, then IDLE. This is mandatory: the loader presents the next address one cycle after it sees ready, so the stale address must not be re-accepted.
- Latency, counted from the request-accept edge to `rom_ready` high:
  - Hit or OOB: EXTRA_WAIT+2.
  - Miss: EXTRA_WAIT+SRAM_LAT+3.
  - Defaults: hit 2, miss 4.
- Minimum spacing between consecutive accepts: latency+2.
- Mid-transaction events:
  - `rom_read_en` dropping or `rom_addr` changing is ignored. The transaction completes and `rom_ready` still pulses.
  - `rom_inval` during SRAM_WAIT: the current response is still served, but the word is not retained (buffer stays invalid).
  - `rom_inval` in any other state clears valid on the next edge.
  - `rom_inval` in the same cycle as a LOOKUP hit: inval wins, and the request is treated as a miss.
- OOB requests never touch SRAM or the buffer. `oob_err` clears only on reset.
- Address width: OOB comparison uses the full 32 bits. The tag is the full addr[31:2]; no aliasing.
- Async reset mid-transaction:
  - Immediately forces all reset values.
  - An in-flight SRAM word is discarded.
  - No `rom_ready` is produced for the aborted request.

Optional Feature:
- ROM_WORD_BUF_EN
  - Defined: the word buffer operates as described above.
  - Undefined: no buffer storage. Every in-bounds request is a miss, and `rom_inval` is ignored. Latency, handshake and OOB behaviour are otherwise identical.

Decomposition:
- Package `rom_resp_pkg`:
  - state enum (IDLE, WAIT, LOOKUP, SRAM_WAIT, RESP, RECOVER);
  - OOB fill byte constant 8'h00;
  - byte-lane select function (word, addr[1:0]) -> byte.
- Sub-module `rom_word_buf`: valid/tag/data registers, hit compare, fill, invalidate. It is instantiated only under ROM_WORD_BUF_EN.

Test Plan:
- Sequential read, SRAM word0=32'h6D736100, bytes 0..3 read with loader-style handshake -> data 00,61,73,6D; exactly 1 `sram_rd_en`; first `rom_ready` 4 cycles after accept, the rest 2 cycles after accept.
- Read addr 0x30 then 0x34 -> two SRAM accesses; `sram_addr`=12 then 13.
- `rom_read_en` held high for 10 cycles with addr 5 (word1 = 32'hAABBCCDD) -> `rom_ready` pulses with CC, RECOVER honoured; no double-accept within latency+2 cycles.
- Addr ROM_BYTES (0x1000) -> data 00, `oob_err`=1 and stays 1; no `sram_rd_en`; a following read of addr 0 still succeeds.
- Read addr 0, pulse `rom_inval`, read addr 1 -> a second `sram_rd_en` occurs. Repeat with the inval during SRAM_WAIT -> the response is correct and the next same-word read misses.
- Deassert `rst_n` during SRAM_WAIT -> `rom_ready` never pulses, outputs reset immediately; after release a read of addr 2 returns the correct byte with miss latency.
